lsu_ctrl: RTL and testbench

Load/store unit sitting between the execute stage and the word-addressed data memory. Accepts one load or store request per transaction on a valid/ready handshake, forms the effective address, converts the RV32I funct3 into byte strobes and lane-shifted write data, and sequences the memory access with a fixed, parameterised read latency. It returns sign- or zero-extended load data to writeback on a response handshake and flags illegal or misaligned requests.

---
 rtl/lsu_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between execute and a word-addressed data memory.
//
// One request per transaction on a valid/ready handshake. The unit forms the
// effective address and turns the RV32I funct3 into byte strobes and
// lane-shifted store data. Loads wait a fixed MEM_LAT cycles for read data, which
// is then sign- or zero-extended. Illegal requests are flagged on resp_err_o.
//
// Parameter
//   MEM_LAT       read latency from mem_re_o to valid mem_rdata_i (1..4)
// Build option
//   LSU_MISALIGN_TRAP_EN  defined: misaligned H/W requests report resp_err_o
//                         with no memory access. Undefined: the low address
//                         bits are cleared and the access goes ahead.
// Ports
//   clk_i, rst_ni                  clock, async active-low reset
//   req_valid_i / req_ready_o      request handshake
//   req_opcode_i, req_funct3_i     load/store opcode and access size
//   req_base_i, req_imm_i          effective address operands
//   req_wdata_i                    store data (rs2)
//   resp_valid_o / resp_ready_i    response handshake
//   resp_rdata_o, resp_err_o       extended load data, error flag
//   mem_addr_o                     word address ea[31:2]
//   mem_we_o, mem_wstrb_o          one-cycle write strobe and byte enables
//   mem_wdata_o                    lane-shifted write data
//   mem_re_o, mem_rdata_i          one-cycle read strobe, read word

module lsu_ctrl #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [6:0]  req_opcode_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_base_i,
    input  logic [31:0] req_imm_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [29:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_re_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        err_q;
    logic        is_load_q;
    logic        req_ready_q, resp_valid_q, resp_err_q, mem_we_q, mem_re_q;
    logic [31:0] resp_rdata_q, mem_wdata_q;
    logic [29:0] mem_addr_q;
    logic [3:0]  mem_wstrb_q;

    // Request decode, evaluated on the incoming request in IDLE.
    logic [31:0] ea, ea_eff, wdata_sh;
    logic        is_load, is_store, illegal, misal, req_err;
    logic [3:0]  wstrb;

    always_comb begin
        ea       = req_base_i + req_imm_i;
        is_load  = (req_opcode_i == 7'b0000011);
        is_store = (req_opcode_i == 7'b0100011);
        illegal  = !((is_load && (req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
                  || (is_store && (req_funct3_i inside {3'b000, 3'b001, 3'b010})));
        misal    = ((req_funct3_i[1:0] == 2'b01) && ea[0])
                || ((req_funct3_i[1:0] == 2'b10) && (ea[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
        req_err  = illegal || misal;
        ea_eff   = ea;
`else
        req_err  = illegal;
        ea_eff   = ea;
        // Force alignment: clear the low bits a half or word cannot use.
        if (req_funct3_i[1:0] == 2'b01) ea_eff[0]   = 1'b0;
        if (req_funct3_i[1:0] == 2'b10) ea_eff[1:0] = 2'b00;
`endif
        case (req_funct3_i[1:0])
            2'b00:   wstrb = 4'b0001 << ea_eff[1:0];
            2'b01:   wstrb = 4'b0011 << ea_eff[1:0];
            default: wstrb = 4'b1111;
        endcase
        wdata_sh = req_wdata_i << {ea_eff[1:0], 3'b000};
    end

    // Load data extraction from the returned word.
    logic [31:0] lane, load_data;

    always_comb begin
        lane = mem_rdata_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b010:  load_data = lane;
            3'b100:  load_data = {24'd0, lane[7:0]};
            3'b101:  load_data = {16'd0, lane[15:0]};
            default: load_data = 32'd0;
        endcase
    end

    // Strobes are set on the accepting edge so they are visible during ACCESS.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
            err_q        <= 1'b0;
            is_load_q    <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            mem_addr_q   <= 30'd0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_wstrb_q  <= 4'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        state_q     <= StAccess;
                        req_ready_q <= 1'b0;
                        funct3_q    <= req_funct3_i;
                        off_q       <= ea_eff[1:0];
                        err_q       <= req_err;
                        is_load_q   <= is_load;
                        mem_addr_q  <= ea_eff[31:2];
                        if (!req_err) begin
                            if (is_store) begin
                                mem_we_q    <= 1'b1;
                                mem_wstrb_q <= wstrb;
                                mem_wdata_q <= wdata_sh;
                            end else begin
                                mem_re_q <= 1'b1;
                            end
                        end
                    end
                end
                StAccess: begin
                    mem_we_q    <= 1'b0;
                    mem_re_q    <= 1'b0;
                    mem_wstrb_q <= 4'd0;
                    mem_wdata_q <= 32'd0;
                    if (err_q || !is_load_q) begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= err_q;
                        resp_rdata_q <= 32'd0;
                        mem_addr_q   <= 30'd0;
                    end else begin
                        state_q <= StWait;
                        cnt_q   <= MEM_LAT[2:0];
                    end
                end
                StWait: begin
                    // Counter reaching zero on this edge: read data is valid now.
                    if (cnt_q <= 3'd1) begin
                        cnt_q        <= 3'd0;
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= load_data;
                        mem_addr_q   <= 30'd0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StResp: begin
                    if (resp_ready_i) begin
                        state_q      <= StIdle;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= 32'd0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_we_o     = mem_we_q;
    assign mem_wstrb_o  = mem_wstrb_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_re_o     = mem_re_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a vector table on a MEM_LAT=1 instance plus
// hand-written sequences for MEM_LAT=3 timing, response back-pressure and reset
// during a load.

module tb_lsu_ctrl;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [31:0] base, imm, wdata;
    logic        req_valid1, req_valid3, resp_ready;

    logic        req_ready1, resp_valid1, resp_err1, mem_we1, mem_re1;
    logic [31:0] resp_rdata1, mem_wdata1, mem_rdata1;
    logic [29:0] mem_addr1;
    logic [3:0]  mem_wstrb1;

    logic        req_ready3, resp_valid3, resp_err3, mem_we3, mem_re3;
    logic [31:0] resp_rdata3, mem_wdata3, mem_rdata3;
    logic [29:0] mem_addr3;
    logic [3:0]  mem_wstrb3;

    lsu_ctrl #(.MEM_LAT(LAT_A)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid1), .req_ready_o(req_ready1),
        .req_opcode_i(opcode), .req_funct3_i(f3),
        .req_base_i(base), .req_imm_i(imm), .req_wdata_i(wdata),
        .resp_valid_o(resp_valid1), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata1), .resp_err_o(resp_err1),
        .mem_addr_o(mem_addr1), .mem_we_o(mem_we1), .mem_wstrb_o(mem_wstrb1),
        .mem_wdata_o(mem_wdata1), .mem_re_o(mem_re1), .mem_rdata_i(mem_rdata1)
    );

    lsu_ctrl #(.MEM_LAT(LAT_B)) u_dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid3), .req_ready_o(req_ready3),
        .req_opcode_i(opcode), .req_funct3_i(f3),
        .req_base_i(base), .req_imm_i(imm), .req_wdata_i(wdata),
        .resp_valid_o(resp_valid3), .resp_ready_i(1'b1),
        .resp_rdata_o(resp_rdata3), .resp_err_o(resp_err3),
        .mem_addr_o(mem_addr3), .mem_we_o(mem_we3), .mem_wstrb_o(mem_wstrb3),
        .mem_wdata_o(mem_wdata3), .mem_re_o(mem_re3), .mem_rdata_i(mem_rdata3)
    );

    // Memory models: the read word is driven only in the cycle exactly the
    // latency after mem_re; every other cycle carries a filler pattern.
    logic [31:0] rd_word1, rd_word3;
    logic        p1;
    logic [2:0]  p3;
    logic        re_s1, re_s3;

    initial begin
        p1 = 1'b0; p3 = 3'd0;
        mem_rdata1 = 32'h5A5A5A5A; mem_rdata3 = 32'h5A5A5A5A;
    end

    always @(posedge clk_i) begin
        re_s1 = mem_re1;
        re_s3 = mem_re3;
        #1;
        p1 = re_s1;
        p3 = {p3[1:0], re_s3};
        mem_rdata1 = p1 ? rd_word1 : 32'h5A5A5A5A;
        mem_rdata3 = p3[2] ? rd_word3 : 32'h5A5A5A5A;
    end

    int we_cnt, re_cnt;
    always @(posedge clk_i) begin
        if (mem_we1) we_cnt++;
        if (mem_re1) re_cnt++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] imm;
        logic [31:0] wdata;
        logic [31:0] word;
        logic        we;
        logic        re;
        logic [3:0]  strb;
        logic [31:0] wd;
        logic [29:0] addr;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic send(input logic sel3, input logic [6:0] o, input logic [2:0] f,
                        input logic [31:0] b, input logic [31:0] i, input logic [31:0] w);
        @(negedge clk_i);
        opcode = o; f3 = f; base = b; imm = i; wdata = w;
        if (sel3) req_valid3 = 1'b1;
        else      req_valid1 = 1'b1;
        @(posedge clk_i);
        #1;
        req_valid1 = 1'b0;
        req_valid3 = 1'b0;
    endtask

    // Counts edges after the accepting edge until resp_valid, bounded.
    task automatic wait_resp(input logic sel3, output int lat);
        lat = 0;
        while (!(sel3 ? resp_valid3 : resp_valid1) && lat < 12) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " req_ready"}, req_ready1, 1'b1);
        chk({tag, " resp_valid"}, resp_valid1, 1'b0);
        chk({tag, " resp_rdata"}, resp_rdata1, 32'd0);
        chk({tag, " resp_err"}, resp_err1, 1'b0);
        chk({tag, " mem_we"}, mem_we1, 1'b0);
        chk({tag, " mem_re"}, mem_re1, 1'b0);
        chk({tag, " mem_wstrb"}, mem_wstrb1, 4'd0);
        chk({tag, " mem_wdata"}, mem_wdata1, 32'd0);
        chk({tag, " mem_addr"}, mem_addr1, 30'd0);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   lat;
        v = vecs[i];
        rd_word1 = v.word;
        @(negedge clk_i);
        we_cnt = 0;
        re_cnt = 0;
        chk($sformatf("v%0d req_ready idle", i), req_ready1, 1'b1);
        send(1'b0, v.op, v.f3, v.base, v.imm, v.wdata);
        chk($sformatf("v%0d req_ready busy", i), req_ready1, 1'b0);
        chk($sformatf("v%0d mem_we", i), mem_we1, v.we);
        chk($sformatf("v%0d mem_re", i), mem_re1, v.re);
        chk($sformatf("v%0d mem_wstrb", i), mem_wstrb1, v.strb);
        chk($sformatf("v%0d mem_wdata", i), mem_wdata1, v.wd);
        chk($sformatf("v%0d mem_addr", i), mem_addr1, v.addr);
        wait_resp(1'b0, lat);
        chk($sformatf("v%0d resp latency", i), lat, v.re ? 1 + LAT_A : 1);
        chk($sformatf("v%0d resp_rdata", i), resp_rdata1, v.rdata);
        chk($sformatf("v%0d resp_err", i), resp_err1, v.err);
        @(posedge clk_i);
        #1;
        chk($sformatf("v%0d resp_valid drop", i), resp_valid1, 1'b0);
        chk($sformatf("v%0d req_ready back", i), req_ready1, 1'b1);
        chk($sformatf("v%0d we count", i), we_cnt, v.we);
        chk($sformatf("v%0d re count", i), re_cnt, v.re);
    endtask

    initial begin
        int lat;
        opcode = 7'd0; f3 = 3'd0; base = 32'd0; imm = 32'd0; wdata = 32'd0;
        req_valid1 = 1'b0; req_valid3 = 1'b0; resp_ready = 1'b1;
        rd_word1 = 32'd0; rd_word3 = 32'd0;

        // op, f3, base, imm, wdata, word, we, re, strb, wd, addr, rdata, err
        vecs[0]  = '{7'h23, 3'd2, 32'h100, 32'h4, 32'hDEADBEEF, 32'h0,
                     1'b1, 1'b0, 4'hF, 32'hDEADBEEF, 30'h41, 32'h0, 1'b0};
        vecs[1]  = '{7'h23, 3'd0, 32'h100, 32'h3, 32'h000000A5, 32'h0,
                     1'b1, 1'b0, 4'h8, 32'hA5000000, 30'h40, 32'h0, 1'b0};
        vecs[2]  = '{7'h03, 3'd0, 32'h103, 32'h0, 32'h0, 32'hA5000000,
                     1'b0, 1'b1, 4'h0, 32'h0, 30'h40, 32'hFFFFFFA5, 1'b0};
        vecs[3]  = '{7'h03, 3'd4, 32'h103, 32'h0, 32'h0, 32'hA5000000,
                     1'b0, 1'b1, 4'h0, 32'h0, 30'h40, 32'h000000A5, 1'b0};
        vecs[4]  = '{7'h03, 3'd1, 32'h30, 32'hFFFFFFF2, 32'h0, 32'h80011234,
                     1'b0, 1'b1, 4'h0, 32'h0, 30'h8, 32'hFFFF8001, 1'b0};
        vecs[5]  = '{7'h03, 3'd5, 32'h22, 32'h0, 32'h0, 32'h80011234,
                     1'b0, 1'b1, 4'h0, 32'h0, 30'h8, 32'h00008001, 1'b0};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[6]  = '{7'h03, 3'd2, 32'h2, 32'h0, 32'h0, 32'h12345678,
                     1'b0, 1'b0, 4'h0, 32'h0, 30'h0, 32'h0, 1'b1};
        vecs[12] = '{7'h23, 3'd1, 32'h101, 32'h0, 32'h00001234, 32'h0,
                     1'b0, 1'b0, 4'h0, 32'h0, 30'h40, 32'h0, 1'b1};
`else
        vecs[6]  = '{7'h03, 3'd2, 32'h2, 32'h0, 32'h0, 32'h12345678,
                     1'b0, 1'b1, 4'h0, 32'h0, 30'h0, 32'h12345678, 1'b0};
        vecs[12] = '{7'h23, 3'd1, 32'h101, 32'h0, 32'h00001234, 32'h0,
                     1'b1, 1'b0, 4'h3, 32'h00001234, 30'h40, 32'h0, 1'b0};
`endif
        vecs[7]  = '{7'h33, 3'd0, 32'h100, 32'h0, 32'h11111111, 32'h0,
                     1'b0, 1'b0, 4'h0, 32'h0, 30'h40, 32'h0, 1'b1};
        vecs[8]  = '{7'h23, 3'd4, 32'h100, 32'h0, 32'h22222222, 32'h0,
                     1'b0, 1'b0, 4'h0, 32'h0, 30'h40, 32'h0, 1'b1};
        vecs[9]  = '{7'h23, 3'd1, 32'h100, 32'h6, 32'h0000BEEF, 32'h0,
                     1'b1, 1'b0, 4'hC, 32'hBEEF0000, 30'h41, 32'h0, 1'b0};
        vecs[10] = '{7'h03, 3'd0, 32'h101, 32'h0, 32'h0, 32'h00007F00,
                     1'b0, 1'b1, 4'h0, 32'h0, 30'h40, 32'h0000007F, 1'b0};
        vecs[11] = '{7'h03, 3'd2, 32'hFFFFFFFC, 32'h8, 32'h0, 32'hCAFEF00D,
                     1'b0, 1'b1, 4'h0, 32'h0, 30'h1, 32'hCAFEF00D, 1'b0};
        vecs[13] = '{7'h03, 3'd3, 32'h100, 32'h0, 32'h0, 32'h0,
                     1'b0, 1'b0, 4'h0, 32'h0, 30'h40, 32'h0, 1'b1};

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk_reset("reset");
        chk("reset dut3 req_ready", req_ready3, 1'b1);
        chk("reset dut3 resp_valid", resp_valid3, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(i);

        // LH with MEM_LAT=3: response four edges after acceptance
        rd_word3 = 32'h80011234;
        send(1'b1, 7'h03, 3'd1, 32'h22, 32'h0, 32'h0);
        chk("lat3 mem_re", mem_re3, 1'b1);
        chk("lat3 mem_addr", mem_addr3, 30'h8);
        wait_resp(1'b1, lat);
        chk("lat3 resp latency", lat, 1 + LAT_B);
        chk("lat3 resp_rdata", resp_rdata3, 32'hFFFF8001);
        chk("lat3 resp_err", resp_err3, 1'b0);
        @(posedge clk_i);
        #1;
        chk("lat3 resp_valid drop", resp_valid3, 1'b0);
        chk("lat3 req_ready back", req_ready3, 1'b1);

        // Back-pressure: hold resp_ready low for 5 cycles in RESP
        resp_ready = 1'b0;
        rd_word1 = 32'hA5000000;
        @(negedge clk_i);
        re_cnt = 0;
        send(1'b0, 7'h03, 3'd4, 32'h103, 32'h0, 32'h0);
        wait_resp(1'b0, lat);
        chk("hold latency", lat, 1 + LAT_A);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("hold%0d resp_valid", k), resp_valid1, 1'b1);
            chk($sformatf("hold%0d resp_rdata", k), resp_rdata1, 32'h000000A5);
            chk($sformatf("hold%0d resp_err", k), resp_err1, 1'b0);
            chk($sformatf("hold%0d req_ready", k), req_ready1, 1'b0);
            chk($sformatf("hold%0d strobes", k), {mem_we1, mem_re1}, 2'b00);
        end
        chk("hold re count", re_cnt, 1);
        resp_ready = 1'b1;
        @(posedge clk_i);
        #1;
        chk("hold release resp_valid", resp_valid1, 1'b0);
        chk("hold release req_ready", req_ready1, 1'b1);

        // Reset while the load sits in WAIT: abandoned, no response
        rd_word1 = 32'h12345678;
        send(1'b0, 7'h03, 3'd2, 32'h200, 32'h0, 32'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        chk_reset("midrst");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("postrst%0d resp_valid", k), resp_valid1, 1'b0);
            chk($sformatf("postrst%0d req_ready", k), req_ready1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
